// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared constants, state enum and lane types for the Keccak absorb slice
package keccak_pkg;

  localparam int         LANE_W        = 64;
  localparam int         NUM_LANES     = 25;
  localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
  localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END       = 8'h80;

  typedef logic [4:0] lane_idx_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_WR,
    S_PAD_RD,
    S_PAD_WR,
    S_PERM_ENTER,
    S_PERM_PULSE,
    S_PERM_WAIT,
    S_DONE
  } absorb_state_t;

  // Keeps the low nbytes bytes of a lane (nbytes already clamped to 0..8).
  function automatic logic [LANE_W-1:0] byte_keep_mask(input logic [3:0] nbytes);
    logic [LANE_W-1:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_pad_gen.sv
// rtl/keccak_pad_gen.sv - combinational multi-rate pad word generator
// Build option: KECCAK_SHA3_PAD_EN selects the SHA-3 suffix 0x06, otherwise Keccak 0x01.
// Ports:
//   pos          byte position of the domain suffix inside the pad lane
//   is_last_lane pad lane is the last rate lane, so the 0x80 end marker lands here too
//   end_only     second pad pass: only the end marker, no suffix
//   pad_word     value to XOR into the pad lane
//   need_second  end marker still has to go to the last rate lane
module keccak_pad_gen
  import keccak_pkg::*;
(
  input  logic [2:0]        pos,
  input  logic              is_last_lane,
  input  logic              end_only,
  output logic [LANE_W-1:0] pad_word,
  output logic              need_second
);

`ifdef KECCAK_SHA3_PAD_EN
  localparam logic [7:0] SUFFIX = SUFFIX_SHA3;
`else
  localparam logic [7:0] SUFFIX = SUFFIX_KECCAK;
`endif

  logic [LANE_W-1:0] suffix_word;
  logic [LANE_W-1:0] end_word;

  assign suffix_word = end_only ? '0 : ({56'b0, SUFFIX} << {pos, 3'b000});
  // Suffix and end marker simply XOR together when both fall in the same lane.
  assign end_word    = is_last_lane ? {PAD_END, 56'b0} : '0;
  assign pad_word    = suffix_word ^ end_word;
  assign need_second = !is_last_lane;

endmodule

// File: rtl/keccak_absorb.sv
// rtl/keccak_absorb.sv - Keccak-f[1600] absorb loader: clear, XOR message lanes, pad, hand off to round CU
// Build option: KECCAK_SHA3_PAD_EN (SHA-3 suffix 0x06; undefined gives Keccak suffix 0x01).
// Ports:
//   clock, reset          posedge clock, synchronous active-low reset
//   start                 begins a new message when idle
//   in_data/in_valid/in_last/in_bytes/in_ready  message word stream, byte 0 in bits [7:0]
//   mem_own               1: this block owns the state file, 0: round datapath owns it
//   rd_addr/rd_data       state read port, data one cycle after address
//   wr_en/wr_addr/wr_data state write port
//   perm_start/perm_done  round CU handshake (done rising edge is used)
//   busy/absorb_done      message in progress / padded state fully permuted
module keccak_absorb #(
  parameter int RATE_LANES = 17,
  parameter int LANE_W     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [3:0]        in_bytes,
  output logic              in_ready,
  output logic              mem_own,
  output logic [4:0]        rd_addr,
  input  logic [LANE_W-1:0] rd_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [LANE_W-1:0] wr_data,
  output logic              perm_start,
  input  logic              perm_done,
  output logic              busy,
  output logic              absorb_done
);
  import keccak_pkg::*;

  localparam lane_idx_t LAST_RATE = lane_idx_t'(RATE_LANES - 1);
  localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

  absorb_state_t     state, state_n;
  lane_idx_t         lane, lane_n;
  lane_idx_t         pad_lane, pad_lane_n;
  logic [2:0]        pad_pos, pad_pos_n;
  logic              pad_second, pad_second_n;
  logic              final_blk, final_blk_n;
  logic              pad_after_perm, pad_after_perm_n;
  logic [LANE_W-1:0] word_q, word_n;
  logic              last_q, last_n;
  logic [3:0]        bytes_q, bytes_n;
  logic              perm_done_q;
  logic              perm_rise;
  logic [3:0]        bytes_clamped;
  logic [LANE_W-1:0] pad_word;
  logic              need_second;

  assign bytes_clamped = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign perm_rise     = perm_done && !perm_done_q;

  keccak_pad_gen u_pad_gen (
    .pos          (pad_pos),
    .is_last_lane (pad_lane == LAST_RATE),
    .end_only     (pad_second),
    .pad_word     (pad_word),
    .need_second  (need_second)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_IDLE;
      lane           <= '0;
      pad_lane       <= '0;
      pad_pos        <= '0;
      pad_second     <= 1'b0;
      final_blk      <= 1'b0;
      pad_after_perm <= 1'b0;
      word_q         <= '0;
      last_q         <= 1'b0;
      bytes_q        <= '0;
      perm_done_q    <= 1'b0;
    end else begin
      state          <= state_n;
      lane           <= lane_n;
      pad_lane       <= pad_lane_n;
      pad_pos        <= pad_pos_n;
      pad_second     <= pad_second_n;
      final_blk      <= final_blk_n;
      pad_after_perm <= pad_after_perm_n;
      word_q         <= word_n;
      last_q         <= last_n;
      bytes_q        <= bytes_n;
      perm_done_q    <= perm_done;
    end
  end

  always_comb begin
    state_n          = state;
    lane_n           = lane;
    pad_lane_n       = pad_lane;
    pad_pos_n        = pad_pos;
    pad_second_n     = pad_second;
    final_blk_n      = final_blk;
    pad_after_perm_n = pad_after_perm;
    word_n           = word_q;
    last_n           = last_q;
    bytes_n          = bytes_q;
    in_ready         = 1'b0;
    mem_own          = 1'b1;
    rd_addr          = '0;
    wr_en            = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;
    perm_start       = 1'b0;
    absorb_done      = 1'b0;
    busy             = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n          = S_CLEAR;
          lane_n           = '0;
          final_blk_n      = 1'b0;
          pad_after_perm_n = 1'b0;
        end
      end

      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = lane;
        if (lane == LAST_LANE) begin
          lane_n  = '0;
          state_n = S_WAIT_IN;
        end else begin
          lane_n = lane + 1'b1;
        end
      end

      S_WAIT_IN: begin
        in_ready = 1'b1;
        rd_addr  = lane;
        if (in_valid) begin
          word_n  = in_data;
          last_n  = in_last;
          bytes_n = bytes_clamped;
          if (in_last && bytes_clamped == 4'd0) begin
            state_n      = S_PAD_RD;
            pad_lane_n   = lane;
            pad_pos_n    = '0;
            pad_second_n = 1'b0;
          end else begin
            state_n = S_WR;
          end
        end
      end

      S_WR: begin
        rd_addr      = lane;
        wr_en        = 1'b1;
        wr_addr      = lane;
        wr_data      = rd_data ^ (last_q ? (word_q & byte_keep_mask(bytes_q)) : word_q);
        pad_second_n = 1'b0;
        if (last_q && bytes_q != 4'd8) begin
          state_n    = S_PAD_RD;
          pad_lane_n = lane;
          pad_pos_n  = bytes_q[2:0];
        end else if (last_q) begin
          pad_pos_n = '0;
          if (lane == LAST_RATE) begin
            // Message filled the block exactly: permute first, pad lands in lane 0 of a fresh block.
            state_n          = S_PERM_ENTER;
            pad_after_perm_n = 1'b1;
            pad_lane_n       = '0;
            lane_n           = '0;
          end else begin
            state_n    = S_PAD_RD;
            pad_lane_n = lane + 1'b1;
          end
        end else if (lane == LAST_RATE) begin
          state_n = S_PERM_ENTER;
          lane_n  = '0;
        end else begin
          lane_n  = lane + 1'b1;
          state_n = S_WAIT_IN;
        end
      end

      S_PAD_RD: begin
        rd_addr = pad_lane;
        state_n = S_PAD_WR;
      end

      S_PAD_WR: begin
        rd_addr = pad_lane;
        wr_en   = 1'b1;
        wr_addr = pad_lane;
        wr_data = rd_data ^ pad_word;
        if (need_second) begin
          pad_lane_n   = LAST_RATE;
          pad_second_n = 1'b1;
          state_n      = S_PAD_RD;
        end else begin
          final_blk_n = 1'b1;
          state_n     = S_PERM_ENTER;
        end
      end

      S_PERM_ENTER: begin
        mem_own = 1'b0;
        state_n = S_PERM_PULSE;
      end

      S_PERM_PULSE: begin
        mem_own    = 1'b0;
        perm_start = 1'b1;
        state_n    = S_PERM_WAIT;
      end

      S_PERM_WAIT: begin
        mem_own = 1'b0;
        if (perm_rise) begin
          if (final_blk) begin
            state_n = S_DONE;
          end else if (pad_after_perm) begin
            pad_after_perm_n = 1'b0;
            pad_second_n     = 1'b0;
            state_n          = S_PAD_RD;
          end else begin
            state_n = S_WAIT_IN;
          end
        end
      end

      S_DONE: begin
        absorb_done = 1'b1;
        final_blk_n = 1'b0;
        state_n     = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_keccak_absorb.sv
// tb/tb_keccak_absorb.sv - table-driven bench for keccak_absorb with state-file and round CU models
module tb_keccak_absorb;

`ifdef KECCAK_SHA3_PAD_EN
  localparam logic [63:0] S = 64'h06;
`else
  localparam logic [63:0] S = 64'h01;
`endif
  localparam logic [63:0] E    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] BASE = 64'hF0E1_D2C3_B4A5_9600;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, perm_done;
  logic [63:0] in_data, rd_data, wr_data;
  logic [3:0]  in_bytes;
  logic        in_ready, mem_own, wr_en, perm_start, busy, absorb_done;
  logic [4:0]  rd_addr, wr_addr;
  logic        scramble_req, perm_apply;
  logic [63:0] mem [32];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  keccak_absorb dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .in_ready    (in_ready),
    .mem_own     (mem_own),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .perm_start  (perm_start),
    .perm_done   (perm_done),
    .busy        (busy),
    .absorb_done (absorb_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // State file: synchronous read; the stand-in permutation bumps capacity lane 24.
  always @(posedge clock) begin
    if (scramble_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (perm_apply) mem[24] <= mem[24] + 64'd1;
    end
    rd_data <= mem[rd_addr];
  end

  typedef struct {
    int          nwords;
    logic [3:0]  last_bytes;
    logic [63:0] w0;
    int          exp_perms;
    logic [63:0] exp_l0;
    logic [63:0] exp_l16;
    int          xi;
    logic [63:0] exp_x;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] msg_word(input vec_t v, input int i);
    return (i == 0) ? v.w0 : (BASE ^ 64'(i));
  endfunction

  task automatic run_msg(input vec_t v, input int k);
    int nsend, idx, countdown, hold, perms, rise_cyc, first_ready, c0, own_viol;
    bit acc, done;
    nsend = (v.nwords == 0) ? 1 : v.nwords;
    @(negedge clock); scramble_req = 1'b1;
    @(negedge clock); scramble_req = 1'b0;
    in_valid = 1'b1;
    in_data  = msg_word(v, 0);
    in_last  = (nsend == 1);
    in_bytes = v.last_bytes;
    c0 = cyc;
    start = 1'b1;
    @(negedge clock);
    idx = 0; acc = 0; countdown = -1; hold = 0; perms = 0;
    rise_cyc = -100; first_ready = -1; own_viol = 0; done = 0;
    for (int t = 0; t < 600 && !done; t++) begin
      start      = (t % 5 == 2);
      perm_apply = 1'b0;
      if (acc) begin
        acc = 0;
        check($sformatf("v%0d_ready_drop", k), 64'(in_ready), 64'd0);
        idx++;
        if (idx < nsend) begin
          in_data = msg_word(v, idx);
          in_last = (idx == nsend - 1);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_ready && first_ready < 0) first_ready = cyc;
      if (in_valid && in_ready) acc = 1;
      if (wr_en && !mem_own) own_viol++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) perm_done = 1'b0;
      end
      if (countdown > 0) countdown--;
      else if (countdown == 0) begin
        perm_done  = 1'b1;
        perm_apply = 1'b1;
        rise_cyc   = cyc;
        hold       = 2;
        countdown  = -1;
      end
      if (perm_start) begin
        perms++;
        if (mem_own) own_viol++;
        countdown = 3;
      end
      if (absorb_done) begin
        check($sformatf("v%0d_done_lat", k), 64'(cyc), 64'(rise_cyc + 1));
        done = 1;
      end
      if (!done) @(negedge clock);
    end
    start      = 1'b0;
    in_valid   = 1'b0;
    perm_done  = 1'b0;
    perm_apply = 1'b0;
    check($sformatf("v%0d_finished", k), 64'(done), 64'd1);
    @(negedge clock);
    check($sformatf("v%0d_busy_after", k), 64'(busy), 64'd0);
    check($sformatf("v%0d_done_pulse", k), 64'(absorb_done), 64'd0);
    check($sformatf("v%0d_clear_lat", k), 64'(first_ready - c0), 64'd26);
    check($sformatf("v%0d_perms", k), 64'(perms), 64'(v.exp_perms));
    check($sformatf("v%0d_own", k), 64'(own_viol), 64'd0);
    check($sformatf("v%0d_lane0", k), mem[0], v.exp_l0);
    check($sformatf("v%0d_lane16", k), mem[16], v.exp_l16);
    check($sformatf("v%0d_lane%0d", k, v.xi), mem[v.xi], v.exp_x);
    check($sformatf("v%0d_lane24", k), mem[24], 64'(v.exp_perms));
  endtask

  initial begin
    bit found;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0;
    in_data = '0; perm_done = 1'b0; scramble_req = 1'b0; perm_apply = 1'b0;

    //          nwords bytes w0                       perms l0                                   l16                                   xi  lane[xi]
    vecs[0] = '{0,  4'd0, 64'hDEAD_BEEF_DEAD_BEEF, 1, S,                                     E,                                     1,  64'd0};
    vecs[1] = '{1,  4'd3, 64'h0000_0000_0063_6261, 1, 64'h636261 | (S << 24),                E,                                     1,  64'd0};
    vecs[2] = '{17, 4'd8, BASE,                    2, BASE ^ S,                              (BASE ^ 64'd16) ^ E,                   1,  BASE ^ 64'd1};
    vecs[3] = '{17, 4'd7, BASE,                    1, BASE,                                  64'h00E1_D2C3_B4A5_9610 ^ (S << 56) ^ E, 15, BASE ^ 64'd15};
    vecs[4] = '{2,  4'd8, BASE,                    1, BASE,                                  E,                                     2,  S};
    vecs[5] = '{3,  4'd9, BASE,                    1, BASE,                                  E,                                     3,  S};
    vecs[6] = '{1,  4'd5, BASE,                    1, 64'h0000_00C3_B4A5_9600 ^ (S << 40),   E,                                     1,  64'd0};
    vecs[7] = '{16, 4'd8, BASE,                    1, BASE,                                  S ^ E,                                 15, BASE ^ 64'd15};
    vecs[8] = '{18, 4'd2, BASE,                    2, 64'hF0E1_D2C3_B4A5_0011 ^ (S << 16),   (BASE ^ 64'd16) ^ E,                   1,  BASE ^ 64'd1};

    repeat (3) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_own", 64'(mem_own), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_perm_start", 64'(perm_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_absorb_done", 64'(absorb_done), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);

    for (int k = 0; k < 9; k++) run_msg(vecs[k], k);

    // Reset in the 5th permutation wait cycle; round CU never answers.
    @(negedge clock);
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_bytes = 4'd0; in_data = '1;
    @(negedge clock);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (perm_start) found = 1;
      else @(negedge clock);
    end
    in_valid = 1'b0;
    check("rst_perm_seen", 64'(found), 64'd1);
    repeat (5) @(negedge clock);
    check("rst_wait_own", 64'(mem_own), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_mem_own", 64'(mem_own), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_perm_start", 64'(perm_start), 64'd0);
    reset = 1'b1;
    run_msg(vecs[1], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_absorb.md
# keccak_absorb

Upstream loader for the Keccak‑f[1600] round datapath. Clears the 25×64‑bit state file, XORs incoming 64‑bit message words into the rate lanes, and applies multi‑rate padding. After each full rate block and after the padded final block, it hands the state file to the round control unit and waits for completion. It sits between the message source and the round CU, time‑sharing the state file with the round datapath.

## Interface
Parameters:
- RATE_LANES, 17, number of rate lanes per block (17 gives SHA3‑256, 1088 bits); legal range 1..24
- LANE_W, 64, lane width in bits; fixed

Ports:
- clock  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active‑low; sampled on posedge clock
- start  input  1  pulse; begins a new message when idle
- in_data  input  64  message word; byte 0 in bits [7:0]
- in_valid  input  1  in_data, in_last and in_bytes are valid
- in_last  input  1  this is the final word of the message
- in_bytes  input  4  valid bytes in the final word, 0..8; values above 8 are treated as 8; ignored unless in_last
- in_ready  output  1  block accepts a word this cycle
- mem_own  output  1  1: this block drives the state file; 0: the round datapath drives it
- rd_addr  output  5  state lane address, lane index x+5y
- rd_data  input  64  state read data, valid one cycle after rd_addr
- wr_en, wr_addr[4:0], wr_data[63:0]  output  lane write port
- perm_start  output  1  one‑cycle start pulse to the round CU
- perm_done  input  1  round CU done level; the rising edge is used
- busy  output  1  high from start acceptance until absorb_done
- absorb_done  output  1  one‑cycle pulse; the padded state is fully permuted

## Operation
- IDLE: on `start`, go to CLEAR. `start` is ignored in every other state.
- CLEAR: write 0 to lanes 0..24 (25 cycles, wr_en=1), then lane:=0 and go to WAIT_IN.
- WAIT_IN:
  - in_ready=1 and rd_addr=lane.
  - On in_valid, capture the word and go to WR.
  - A word with in_last and in_bytes=0 carries no data and goes straight to PAD.
- WR:
  - Write rd_data ^ masked word to the current lane. The mask keeps the low in_bytes bytes on the last word.
  - Then apply the first matching rule:
    - If the word was the last and in_bytes<8: go to PAD at byte position in_bytes of the same lane.
    - If the word was the last and in_bytes=8: go to PAD at byte 0 of lane+1. If lane was RATE_LANES‑1, first run PERM, then PAD at lane 0.
    - If lane=RATE_LANES‑1: go to PERM, then return to WAIT_IN with lane 0.
    - Otherwise: lane+1, back to WAIT_IN.
- PAD (read cycle then write cycle per lane):
  - Pad word = suffix << 8·pos.
  - When the pad lane is RATE_LANES‑1, also XOR 0x80 << 56, so suffix and 0x80 combine in one lane when both fall there.
  - If the pad lane ≠ RATE_LANES‑1, do a second read/write to lane RATE_LANES‑1 with 0x80 << 56.
  - Then go to PERM with the final flag set.
- PERM:
  - mem_own:=0, pulse perm_start for one cycle, then wait for a perm_done rising edge.
  - On that edge, mem_own:=1.
  - If final, pulse absorb_done and go to IDLE; otherwise go to WAIT_IN.
- perm_done edges outside PERM are ignored.

## Timing
- Reset values: in_ready=0, mem_own=1, wr_en=0, perm_start=0, busy=0, absorb_done=0, rd_addr=0, wr_addr=0, wr_data=0; state IDLE, lane 0.
- Reset low in any state (mid‑CLEAR, mid‑PERM) returns to IDLE on that edge. A partial state file is not recovered.
- Word throughput: 2 cycles per word (accept, write). in_ready drops in the cycle after acceptance.
- CLEAR latency is 25 cycles from the start edge to the first in_ready.
- Pad latency is 2 cycles per pad lane, i.e. 2 or 4 cycles.
- absorb_done asserts 1 cycle after the perm_done rising edge of the final block.
- perm_start asserts 1 cycle after entering PERM.
- Lane counter wraps from RATE_LANES‑1 to 0 only via PERM.

## Configuration
- KECCAK_SHA3_PAD_EN defined: domain suffix = 0x06 (FIPS‑202 SHA‑3).
- KECCAK_SHA3_PAD_EN undefined: suffix = 0x01 (original Keccak pad10*1).
- All other behaviour is identical.

## Structure
- Shared package `keccak_pkg`:
  - constants LANE_W, NUM_LANES=25, SUFFIX_SHA3=8'h06, SUFFIX_KECCAK=8'h01, PAD_END=8'h80
  - absorb state enum
  - lane‑index typedef `lane_idx_t` (5 bits)
- One sub‑module: `keccak_pad_gen`, combinational. Inputs: pos, lane, is_last_lane. Outputs: pad word and whether a second pad lane is needed.

## Test plan
- Empty message (start, then in_last, in_bytes=0): lane0 ^= 0x06 and lane16 ^= 0x8000000000000000, one perm_start, absorb_done after perm_done; all other lanes stay 0.
- One word 0x00000000_00636261 ("abc", in_last, in_bytes=3): lane0 = 0x0000000006636261 and lane16 = 0x8000000000000000.
- 17 full words, the last flagged with in_bytes=8: two perm_start pulses; the second block has lane0 ^= 0x06 and lane16 ^= 0x80<<56.
- 17 words with the last flagged in_bytes=7: lane16 byte 7 = 0x86, one permutation only.
- Reset driven low in the 5th PERM wait cycle: next cycle mem_own=1, busy=0, IDLE; a new start works normally.
- Build without KECCAK_SHA3_PAD_EN, empty message: lane0 = 0x01.
